// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill count, almost-full/almost-empty flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise Dout is registered on each accepted read.
module sync_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_wr,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  en_rd,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wrPtr;
  logic [ADDR_WIDTH:0]   r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almostEmpty;
  logic                  r_almostFull;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wrAccept;
  logic                  w_rdAccept;
  logic [ADDR_WIDTH:0]   w_countNext;

  assign w_wrAccept = en_wr && !r_full;
  assign w_rdAccept = en_rd && !r_empty;

  always_comb begin
    w_countNext = r_count;
    case ({w_wrAccept, w_rdAccept})
      2'b10:   w_countNext = r_count + C_ONE;
      2'b01:   w_countNext = r_count - C_ONE;
      default: w_countNext = r_count;
    endcase
  end

  // Flags are registered from the next-state count so they always agree with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_almostFull  <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + C_ONE;
      if (w_rdAccept) r_rdPtr <= r_rdPtr + C_ONE;
      r_count       <= w_countNext;
      r_empty       <= (w_countNext == '0);
      r_full        <= (w_countNext == C_DEPTH);
      r_almostEmpty <= (w_countNext <= C_AE);
      r_almostFull  <= (w_countNext >= C_AF);
      r_overflow    <= en_wr && r_full;
      r_underflow   <= en_rd && r_empty;
    end
  end

  // Storage is deliberately left unreset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_wrAccept) r_mem[r_wrPtr[ADDR_WIDTH-1:0]] <= Din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] w_dout;

  assign w_dout = r_empty ? '0 : r_mem[r_rdPtr[ADDR_WIDTH-1:0]];
  assign Dout   = w_dout;
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (w_rdAccept) begin
      r_dout <= r_mem[r_rdPtr[ADDR_WIDTH-1:0]];
    end
  end

  assign Dout = r_dout;
`endif

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almostEmpty;
  assign almost_full  = r_almostFull;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives sync_fifo with directed and random traffic and compares it against a queue-based model.
// Works in both read modes; SYNC_FIFO_FWFT_EN selects the fall-through expectation for Dout.
module tb_sync_fifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_wr = 1'b0;
  logic          en_rd = 1'b0;
  logic [DW-1:0] Din = '0;
  logic [DW-1:0] Dout;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [10:0]   actStatus;

  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] modelLast;
  bit            modelOvf;
  bit            modelUnf;
  int            nVectors = 0;
  int            nMiscompares = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_wr(en_wr),
    .Din(Din),
    .en_rd(en_rd),
    .Dout(Dout),
    .empty(empty),
    .full(full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  assign actStatus = {empty, full, almost_empty, almost_full, overflow, underflow, count};

  function automatic logic [10:0] expStatus();
    int n;
    n = modelQ.size();
    return {n == 0, n == DEPTH, n <= AE, n >= AF, modelOvf, modelUnf, 5'(n)};
  endfunction

  function automatic logic [DW-1:0] expDout();
`ifdef SYNC_FIFO_FWFT_EN
    return (modelQ.size() != 0) ? modelQ[0] : 8'h00;
`else
    return modelLast;
`endif
  endfunction

  // One clock of traffic: drive inputs, let the edge happen, advance the model, settle 1ns past the edge.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [DW-1:0] d);
    int n;
    bit isFull;
    bit isEmpty;
    en_wr = wr;
    en_rd = rd;
    Din   = d;
    @(posedge clk);
    n        = modelQ.size();
    isFull   = (n == DEPTH);
    isEmpty  = (n == 0);
    modelOvf = wr && isFull;
    modelUnf = rd && isEmpty;
    if (rd && !isEmpty) modelLast = modelQ.pop_front();
    if (wr && !isFull) modelQ.push_back(d);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    modelQ.delete();
    modelLast = '0;
    modelOvf  = 1'b0;
    modelUnf  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    applyReset();
    #2;
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL reset_status: got %b want %b", actStatus, expStatus());
    end
    nVectors++;
    if (Dout !== 8'h00) begin
      nMiscompares++;
      $display("[TB] FAIL reset_dout: got %h want 00", Dout);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      nVectors++;
      if (actStatus !== expStatus()) begin
        nMiscompares++;
        $display("[TB] FAIL fill_status[%0d]: got %b want %b", i, actStatus, expStatus());
      end
      nVectors++;
      if (Dout !== expDout()) begin
        nMiscompares++;
        $display("[TB] FAIL fill_dout[%0d]: got %h want %h", i, Dout, expDout());
      end
    end
    applyStimulus(1'b1, 1'b0, 8'hEE);
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL overflow_pulse: got %b want %b", actStatus, expStatus());
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL overflow_clear: got %b want %b", actStatus, expStatus());
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      nVectors++;
      if (actStatus !== expStatus()) begin
        nMiscompares++;
        $display("[TB] FAIL drain_status[%0d]: got %b want %b", i, actStatus, expStatus());
      end
      nVectors++;
      if (Dout !== expDout()) begin
        nMiscompares++;
        $display("[TB] FAIL drain_dout[%0d]: got %h want %h", i, Dout, expDout());
      end
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL underflow_pulse: got %b want %b", actStatus, expStatus());
    end
    nVectors++;
    if (Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL underflow_dout_hold: got %h want %h", Dout, expDout());
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL underflow_clear: got %b want %b", actStatus, expStatus());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h40 + k));
      nVectors++;
      if (actStatus !== expStatus() || count !== 5'd8) begin
        nMiscompares++;
        $display("[TB] FAIL wrap_status[%0d]: got %b want %b", k, actStatus, expStatus());
      end
      nVectors++;
      if (Dout !== expDout()) begin
        nMiscompares++;
        $display("[TB] FAIL wrap_dout[%0d]: got %h want %h", k, Dout, expDout());
      end
    end
  endtask

  task automatic test_full_read_empty_write();
    while (modelQ.size() < DEPTH) applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 8'h77);
    nVectors++;
    if (actStatus !== expStatus() || count !== 5'd15) begin
      nMiscompares++;
      $display("[TB] FAIL full_plus_read: got %b want %b", actStatus, expStatus());
    end
    nVectors++;
    if (Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL full_plus_read_dout: got %h want %h", Dout, expDout());
    end
    while (modelQ.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h99);
    nVectors++;
    if (actStatus !== expStatus() || count !== 5'd1) begin
      nMiscompares++;
      $display("[TB] FAIL empty_plus_write: got %b want %b", actStatus, expStatus());
    end
    nVectors++;
    if (Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL empty_plus_write_dout: got %h want %h", Dout, expDout());
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    nVectors++;
    if (Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL empty_plus_write_readback: got %h want %h", Dout, expDout());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'hB0 + i));
    applyStimulus(1'b0, 1'b1, 8'h00);
    en_wr = 1'b1;
    Din   = 8'h55;
    #3;
    applyReset();
    #1;
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_status: got %b want %b", actStatus, expStatus());
    end
    nVectors++;
    if (Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_dout: got %h want %h", Dout, expDout());
    end
    @(posedge clk);
    #1;
    nVectors++;
    if (actStatus !== expStatus()) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_held: got %b want %b", actStatus, expStatus());
    end
    en_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h3C);
    nVectors++;
    if (actStatus !== expStatus() || Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL postreset_write: got %b/%h want %b/%h", actStatus, Dout, expStatus(), expDout());
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    nVectors++;
    if (modelLast !== 8'h3C || Dout !== expDout()) begin
      nMiscompares++;
      $display("[TB] FAIL postreset_readback: got %h want %h", Dout, expDout());
    end
  endtask

  task automatic test_random();
    int wrBias;
    for (int c = 0; c < 600; c++) begin
      wrBias = ((c / 60) % 2 == 0) ? 75 : 25;
      applyStimulus($urandom_range(0, 99) < wrBias, $urandom_range(0, 99) < (100 - wrBias), 8'($urandom));
      nVectors++;
      if (actStatus !== expStatus()) begin
        nMiscompares++;
        $display("[TB] FAIL random_status[%0d]: got %b want %b", c, actStatus, expStatus());
      end
      nVectors++;
      if (Dout !== expDout()) begin
        nMiscompares++;
        $display("[TB] FAIL random_dout[%0d]: got %h want %h", c, Dout, expDout());
      end
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    @(negedge clk);
    applyReset();
    #1;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00);
    nVectors++;
    if (Dout !== 8'hA5) begin
      nMiscompares++;
      $display("[TB] FAIL fwft_head: got %h want a5", Dout);
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    nVectors++;
    if (Dout !== 8'h00 || empty !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL fwft_pop: got dout=%h empty=%b want dout=00 empty=1", Dout, empty);
    end
  endtask
`endif

  initial begin
    modelLast = '0;
    modelOvf  = 1'b0;
    modelUnf  = 1'b0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_full_read_empty_write();
    test_reset_mid();
    test_random();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for the common case where the producer and consumer share one clock. It adds a fill count, programmable almost-full and almost-empty thresholds, and sticky-free overflow and underflow error pulses. A compile-time first-word-fall-through read mode is also available. It is used as the generic buffering primitive between same-domain pipeline stages.

## Interface
Parameters:
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 8, word width in bits.
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en_wr  in  1  write request.
- Din  in  DATA_WIDTH  write data.
- en_rd  in  1  read request.
- Dout  out  DATA_WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_WIDTH+1  words stored, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write request refused.
- underflow  out  1  one-cycle pulse: read request refused.

## Operation
- **Pointers:** wr_ptr and rd_ptr are ADDR_WIDTH+1-bit binary counters. The low ADDR_WIDTH bits address memory. Each pointer increments by 1 per accepted op and wraps mod 2^(ADDR_WIDTH+1).
- **Accept rules:**
  - A write is accepted iff en_wr && !full.
  - A read is accepted iff en_rd && !empty.
  - A refused request has no effect on memory, pointers, count or Dout.
- **Full + read:** when full, en_wr && en_rd accepts the read only. The write is refused and overflow pulses.
- **Empty + write:** when empty, en_wr && en_rd accepts the write only. The read is refused and underflow pulses.
- **Count update:**
  - Write only: count+1.
  - Read only: count-1.
  - Both accepted: unchanged.
  - Neither: unchanged.
- **Flag registration:** empty, full, almost_empty and almost_full are registered, computed from the next-state count. They therefore match count in the same cycle.
- **overflow / underflow:** registered, high for exactly the one cycle following the edge at which the refused request was sampled.
- **Memory:** never reset. Contents are unspecified until written.
- **Reset:** asserting rst at any time, including mid-burst, immediately (without a clock edge) forces:
  - pointers, count, Dout, full, almost_full, overflow, underflow = 0;
  - empty = 1, almost_empty = 1.
  - Stored data is discarded.
  - On release, the first accepted op occurs at the first rising edge at which rst is high.

## Timing
- **Write latency:** data written at edge N is readable from edge N+1. empty falls after edge N.
- **Standard read (macro absent):** Dout <= mem[rd_ptr] at the edge where the read is accepted, so there is a 1-cycle latency. Dout holds its value between accepted reads.
- **Flags:** full/empty/almost flags and count change only at clock edges (or asynchronously at reset), never combinationally from en_wr or en_rd.
- **Throughput:** one write and one read per cycle sustained, at any fill level other than 0 or DEPTH.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- **Defined:** first-word-fall-through read.
  - Dout = empty ? 0 : mem[rd_ptr], combinational.
  - The head word is visible in the cycle after it is written into an empty FIFO, with no en_rd.
  - en_rd acts as "pop": the next word, or 0 if the FIFO becomes empty, appears after the edge.
  - Reset value of Dout is 0.
- **Undefined:** standard registered read as described under Timing.
- Accept rules, flags, count and error pulses are identical in both modes.

## Test plan
- **Fill then overflow:** with defaults, reset, then write Din=0..15 on consecutive cycles.
  - almost_full rises after the 14th write and full after the 16th; count=16.
  - A 17th en_wr gives overflow=1 for one cycle; count stays 16.
- **Drain then underflow:** from full, assert en_rd for 16 cycles.
  - Standard mode: Dout=0..15 in order, each one cycle after its read.
  - almost_empty rises when count=2; empty rises after the 16th read.
  - A 17th en_rd gives underflow=1 for one cycle; Dout holds 15.
- **Simultaneous read/write with wrap-around:** at count=8, assert en_wr and en_rd together for 40 cycles with incrementing Din.
  - count stays 8 and no flag toggles.
  - Read data stays in order across pointer wrap.
- **Full-plus-read and empty-plus-write:**
  - At full, en_wr && en_rd: count becomes 15 and overflow pulses.
  - At empty, en_wr && en_rd: count becomes 1 and underflow pulses.
- **Reset mid-operation:** write 5 words, then drop rst between clock edges.
  - All outputs take their reset values immediately.
  - After release, a single write of 0x3C reads back 0x3C (stale data is not returned).
- **FWFT (SYNC_FIFO_FWFT_EN defined):**
  - Write 0xA5 into an empty FIFO: Dout=0xA5 after that edge with en_rd low.
  - A single en_rd pop gives Dout=0 and empty=1.
